// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - fetch/data arbiter for a single-port unified memory
//
// Purpose: two requesters (instruction fetch, data LW/SW) share one memory
// port. Each issues a one-cycle request pulse; the arbiter holds the memory
// strobe until mem_ready, then returns a one-cycle done pulse with registered
// read data. Data has fixed priority over fetch. A wait-cycle watchdog aborts
// an access after TIMEOUT consecutive not-ready cycles and flags err.
//
// Ports:
//   clock, reset_n                  clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request pulse and address
//   if_done/if_rdata                fetch completion pulse and held read word
//   dm_req/dm_we/dm_addr/dm_wdata   data request pulse, store flag, address, data
//   dm_done/dm_rdata                data completion pulse and held load word
//   err                             co-asserted with done on a timed-out access
//   mem_req/mem_we/mem_addr/mem_wdata   memory request side
//   mem_rdata/mem_ready             memory response side
//   busy                            access in progress or request pending
//   overrun                         sticky: request for a port already busy
module memory_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, ACC_DM, ACC_IF, RESP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t state_q, state_d;

  // A pending flag means "accepted but not yet launched"; once launched the
  // port's fields live in the mem_* registers until the access completes.
  logic              dm_pend_q, dm_pend_d;
  logic              if_pend_q, if_pend_d;
  logic              dm_we_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [DATA_W-1:0] dm_wdata_q;
  logic [ADDR_W-1:0] if_addr_q;
  logic [15:0]       wait_cnt_q;

  logic              if_done_q, dm_done_q, err_q, busy_q, overrun_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              dm_acc, if_acc, dm_want, if_want;
  logic              can_launch, launch_dm, launch_if, timeout_hit;
  logic              launch_we;
  logic [ADDR_W-1:0] launch_addr;
  logic [DATA_W-1:0] launch_wdata;

  always_comb begin
    // A pulse is accepted unless its port is already waiting or in service.
    dm_acc      = dm_req && !dm_pend_q && (state_q != ACC_DM);
    if_acc      = if_req && !if_pend_q && (state_q != ACC_IF);
    dm_want     = dm_pend_q || dm_acc;
    if_want     = if_pend_q || if_acc;
    can_launch  = (state_q == IDLE) || (state_q == RESP);
    launch_dm   = can_launch && dm_want;
    launch_if   = can_launch && !dm_want && if_want;
    timeout_hit = (wait_cnt_q == WAIT_LAST);

    // Launch source: captured fields if pending, else the live pulse (bypass).
    launch_we    = 1'b0;
    launch_addr  = if_pend_q ? if_addr_q : if_addr;
    launch_wdata = '0;
    if (launch_dm) begin
      launch_we    = dm_pend_q ? dm_we_q    : dm_we;
      launch_addr  = dm_pend_q ? dm_addr_q  : dm_addr;
      launch_wdata = dm_pend_q ? dm_wdata_q : dm_wdata;
    end

    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (launch_dm)      state_d = ACC_DM;
        else if (launch_if) state_d = ACC_IF;
        else                state_d = IDLE;
      end
      ACC_DM, ACC_IF: begin
        if (mem_ready || timeout_hit) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase

    dm_pend_d = launch_dm ? 1'b0 : (dm_pend_q || dm_acc);
    if_pend_d = launch_if ? 1'b0 : (if_pend_q || if_acc);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dm_pend_q   <= 1'b0;
      if_pend_q   <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      if_addr_q   <= '0;
      wait_cnt_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      dm_pend_q <= dm_pend_d;
      if_pend_q <= if_pend_d;
      busy_q    <= (state_d != IDLE) || dm_pend_d || if_pend_d;

      if (dm_acc) begin
        dm_we_q    <= dm_we;
        dm_addr_q  <= dm_addr;
        dm_wdata_q <= dm_wdata;
      end
      if (if_acc) if_addr_q <= if_addr;

      if ((dm_req && !dm_acc) || (if_req && !if_acc)) overrun_q <= 1'b1;

      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      err_q     <= 1'b0;

      case (state_q)
        IDLE, RESP: begin
          mem_req_q <= 1'b0;
          if (launch_dm || launch_if) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= launch_we;
            mem_addr_q  <= launch_addr;
            mem_wdata_q <= launch_wdata;
            wait_cnt_q  <= '0;
          end
        end
        ACC_DM, ACC_IF: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            if (state_q == ACC_DM) begin
              dm_done_q <= 1'b1;
              if (!mem_we_q) dm_rdata_q <= mem_rdata;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end else if (timeout_hit) begin
            // Watchdog abort: the read word is forced to zero, even for stores.
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            if (state_q == ACC_DM) begin
              dm_done_q  <= 1'b1;
              dm_rdata_q <= '0;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= '0;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        default: mem_req_q <= 1'b0;
      endcase
    end
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_done   = dm_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - self-checking bench for memory_port_arbiter
module tb_memory_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  localparam int P_NONE = 0;
  localparam int P_DM   = 1;
  localparam int P_IF   = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          if_req, dm_req, dm_we, mem_ready;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          if_done, dm_done, err, mem_req, mem_we, busy, overrun;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clock = ~clock;

  memory_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .overrun(overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Transaction-level reference: who owns the memory, what each port is
  // waiting with, and what each port has last returned.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } job_t;

  int            owner;
  int            waited;
  job_t          cur, job_dm, job_if;
  bit            pend_dm, pend_if;
  logic [DW-1:0] m_if_rdata, m_dm_rdata;
  bit            m_if_done, m_dm_done, m_err, m_overrun, m_resp;

  task automatic model_reset();
    owner = P_NONE; waited = 0; cur = '0; job_dm = '0; job_if = '0;
    pend_dm = 0; pend_if = 0; m_if_rdata = '0; m_dm_rdata = '0;
    m_if_done = 0; m_dm_done = 0; m_err = 0; m_overrun = 0; m_resp = 0;
  endtask

  task automatic finish_access(input bit aborted);
    m_resp = 1;
    m_err  = aborted;
    if (owner == P_DM) begin
      m_dm_done = 1;
      if (aborted)      m_dm_rdata = '0;
      else if (!cur.we) m_dm_rdata = mem_rdata;
    end else begin
      m_if_done  = 1;
      m_if_rdata = aborted ? '0 : mem_rdata;
    end
    owner = P_NONE;
  endtask

  task automatic model_edge();
    bit take_dm, take_if;
    take_dm = dm_req && !pend_dm && (owner != P_DM);
    take_if = if_req && !pend_if && (owner != P_IF);
    if ((dm_req && !take_dm) || (if_req && !take_if)) m_overrun = 1;
    if (take_dm) begin
      pend_dm = 1; job_dm.we = dm_we; job_dm.addr = dm_addr; job_dm.wdata = dm_wdata;
    end
    if (take_if) begin
      pend_if = 1; job_if.we = 1'b0; job_if.addr = if_addr; job_if.wdata = '0;
    end
    m_if_done = 0; m_dm_done = 0; m_err = 0; m_resp = 0;
    if (owner != P_NONE) begin
      if (mem_ready) finish_access(1'b0);
      else begin
        waited++;
        if (waited == TO) finish_access(1'b1);
      end
    end else if (pend_dm) begin
      owner = P_DM; cur = job_dm; pend_dm = 0; waited = 0;
    end else if (pend_if) begin
      owner = P_IF; cur = job_if; pend_if = 0; waited = 0;
    end
  endtask

  task automatic compare_all();
    check("mem_req", mem_req, owner != P_NONE);
    if (owner != P_NONE) begin
      check("mem_we", mem_we, cur.we);
      check("mem_addr", mem_addr, cur.addr);
      if (owner == P_DM) check("mem_wdata", mem_wdata, cur.wdata);
    end
    check("if_done", if_done, m_if_done);
    check("dm_done", dm_done, m_dm_done);
    check("err", err, m_err);
    check("if_rdata", if_rdata, m_if_rdata);
    check("dm_rdata", dm_rdata, m_dm_rdata);
    check("busy", busy, (owner != P_NONE) || m_resp || pend_dm || pend_if);
    check("overrun", overrun, m_overrun);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  task automatic pulse_if(input logic [AW-1:0] a);
    if_req = 1'b1; if_addr = a;
  endtask

  task automatic pulse_dm(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
  endtask

  task automatic hold_reset(input int cycles);
    reset_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      model_reset();
      #1;
      compare_all();
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  int stuck;
  int r;

  initial begin
    reset_n = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0;
    dm_wdata = '0; mem_rdata = '0; mem_ready = 0;
    model_reset();
    hold_reset(2);

    // Zero-wait fetch
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    pulse_if(32'h10);
    step();
    check("zw_mem_req", mem_req, 1'b1);
    step();
    check("zw_if_done", if_done, 1'b1);
    check("zw_if_rdata", if_rdata, 32'hDEADBEEF);
    check("zw_err", err, 1'b0);
    step();

    // Store with three wait states
    mem_ready = 1'b0; mem_rdata = 32'h5555AAAA;
    pulse_dm(1'b1, 32'h40, 32'h1234);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_mem_we", mem_we, 1'b1);
      check("st_mem_addr", mem_addr, 32'h40);
    end
    mem_ready = 1'b1;
    step();
    check("st_dm_done", dm_done, 1'b1);
    check("st_dm_rdata", dm_rdata, 32'h0);
    step();

    // Simultaneous fetch and load, zero-wait
    mem_rdata = 32'hA0A0A0A0;
    pulse_if(32'h20);
    pulse_dm(1'b0, 32'h80, 32'h0);
    step();
    check("sim_first_dm", mem_addr, 32'h80);
    step();
    check("sim_dm_done", dm_done, 1'b1);
    mem_rdata = 32'hB1B1B1B1;
    step();
    step();
    check("sim_if_done", if_done, 1'b1);
    check("sim_if_rdata", if_rdata, 32'hB1B1B1B1);
    check("sim_overrun", overrun, 1'b0);
    step();

    // Load times out while a fetch waits behind it
    mem_ready = 1'b0; mem_rdata = 32'hCAFEF00D;
    pulse_dm(1'b0, 32'h50, 32'h0);
    step();
    pulse_if(32'h60);
    for (int i = 0; i < TO; i++) step();
    check("to_dm_done", dm_done, 1'b1);
    check("to_err", err, 1'b1);
    check("to_dm_rdata", dm_rdata, 32'h0);
    check("to_mem_req", mem_req, 1'b0);
    mem_ready = 1'b1;
    step();
    check("to_next_addr", mem_addr, 32'h60);
    step();
    check("to_next_done", if_done, 1'b1);
    step();

    // Duplicate data request while in service
    mem_ready = 1'b0;
    pulse_dm(1'b0, 32'h84, 32'h0);
    step();
    pulse_dm(1'b1, 32'h99, 32'h77);
    step();
    check("dup_overrun", overrun, 1'b1);
    check("dup_addr", mem_addr, 32'h84);
    mem_ready = 1'b1;
    step();
    check("dup_done", dm_done, 1'b1);
    step();
    check("dup_single_done", dm_done, 1'b0);
    step();

    // Reset in the middle of a fetch with two waits elapsed
    mem_ready = 1'b0;
    pulse_if(32'h70);
    step();
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    model_reset();
    compare_all();
    hold_reset(1);
    mem_ready = 1'b1; mem_rdata = 32'h13572468;
    pulse_if(32'h74);
    step();
    step();
    check("post_rst_done", if_done, 1'b1);
    check("post_rst_rdata", if_rdata, 32'h13572468);

    // Randomized traffic against the reference
    stuck = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) pulse_if($urandom);
      if ($urandom_range(0, 3) == 0) pulse_dm(1'($urandom_range(0, 1)), $urandom, $urandom);
      mem_rdata = $urandom;
      if (stuck > 0) begin
        mem_ready = 1'b0;
        stuck--;
      end else begin
        r = $urandom_range(0, 19);
        if (r == 0) begin
          stuck = TO + 2;
          mem_ready = 1'b0;
        end else begin
          mem_ready = (r < 12);
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares one single-port unified memory between the instruction-fetch stage and the data-memory (LW/SW) stage of the multi-cycle processor. Each requester issues a one-cycle request pulse. The arbiter latches it, drives the memory port until the memory acknowledges, and returns a one-cycle done pulse with registered read data. It sits between the stage-enable outputs of the control unit and the memory model, and adds a watchdog so a hung memory cannot lock up the stage sequencing.

## Interface
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data word width
- TIMEOUT, 255, max wait cycles for mem_ready before abort (1..2^16-1)

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  one-cycle fetch request pulse
- if_addr  in  ADDR_W  fetch address, sampled with if_req
- if_done  out  1  one-cycle completion pulse for fetch
- if_rdata  out  DATA_W  fetched word, valid from if_done, held until next if_done
- dm_req  in  1  one-cycle data request pulse
- dm_we  in  1  1 = store (SW), 0 = load (LW), sampled with dm_req
- dm_addr  in  ADDR_W  data address, sampled with dm_req
- dm_wdata  in  DATA_W  store data, sampled with dm_req
- dm_done  out  1  one-cycle completion pulse for data access
- dm_rdata  out  DATA_W  load data, valid from dm_done, held until next dm_done
- err  out  1  co-asserted with a done pulse when that access timed out
- mem_req  out  1  memory access strobe, held until accepted
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory accepts or completes the access in this cycle
- busy  out  1  state ≠ IDLE or any request pending
- overrun  out  1  sticky: request pulse arrived for a port already pending or in service

## Operation
- Reset values: all outputs 0, state IDLE, pending flags 0, latched address/data 0, wait counter 0.
- Per-port pending flag plus captured address, we, and wdata. On a *_req pulse, capture the fields and set pending.
- A pulse for a port that is already pending or in service is ignored: no field overwrite, and overrun is set to 1 (sticky until reset).
- States: IDLE, ACC_DM, ACC_IF, RESP.
- IDLE: if a DM pulse or DM pending → ACC_DM; else if an IF pulse or IF pending → ACC_IF. Data has fixed priority over fetch. A pulse is taken in the same edge it is sampled, i.e. the capture path is bypassed into the memory outputs.
- ACC_x: mem_req=1, and mem_we/mem_addr/mem_wdata come from port x (mem_we=0 for IF). All are stable for the whole state.
- ACC_x exit on mem_ready=1: capture mem_rdata into x_rdata (loads and fetches only; a store leaves dm_rdata unchanged), clear pending x, go to RESP, x_done=1 in RESP.
- Wait counter: cleared on entry to ACC_x and incremented each cycle mem_ready=0. When it reaches TIMEOUT, abort: mem_req drops, go to RESP with x_done=1 and err=1, and x_rdata is written with 0.
- RESP (one cycle): done and err deassert on exit. Next state is ACC_DM if DM pending or pulsing, else ACC_IF if IF pending or pulsing, else IDLE.
- mem_req is 0 in IDLE and RESP.

## Timing
- All outputs are registered; no combinational input→output path.
- Minimum latency: req sampled at edge k → mem_req high after edge k. With mem_ready sampled high at edge k+1, done is high for exactly the cycle after edge k+1. That is 2 cycles from request to done.
- With W wait cycles (mem_ready low at W edges), latency is 2+W.
- Back-to-back: a different port's pending access starts in the cycle after RESP, so there is one idle memory cycle between accesses.
- Simultaneous if_req and dm_req from IDLE: DM is served first and IF immediately after. Total 4 cycles to if_done with zero-wait memory.
- Timeout: the abort done pulse is high for exactly the cycle after the edge where TIMEOUT consecutive not-ready cycles are counted.
- A pulse arriving during RESP for the port just completed is legal: it is a new request, not an overrun.
- reset_n low at any time, including mid-access: immediate return to reset values. mem_req drops asynchronously, the in-flight access is lost, and no done pulse is produced.

## Test plan
- Zero-wait fetch: if_req at edge 0, addr 0x10, mem_ready=1, mem_rdata 0xDEADBEEF → mem_req high cycle 0→1, if_done high cycle 1→2, if_rdata=0xDEADBEEF, err=0.
- Store with 3 wait states: dm_req, dm_we=1, addr 0x40, wdata 0x1234 → mem_we=1, mem_addr=0x40 stable for 4 cycles, dm_done 5 cycles after request, dm_rdata unchanged.
- Simultaneous if_req and dm_req, zero-wait → ACC_DM first, dm_done at cycle 2, if_done at cycle 4, no overrun.
- Timeout with TIMEOUT=4, mem_ready stuck 0 on a load → done with err=1 after 4 not-ready cycles, rdata=0, mem_req low in RESP, next pending request still served.
- Duplicate dm_req during ACC_DM → ignored, overrun=1 stays set, only one dm_done issued, captured address not altered.
- reset_n pulsed low during ACC_IF with 2 waits elapsed → all outputs 0 immediately, no if_done, busy=0. A new if_req after reset completes normally.
